// File: rtl/pipe_fetch.sv
// -----------------------------------------------------------------------------
// pipe_fetch
//
// Fetch stage of a five-stage Y86-64 style pipeline.
// It chooses the fetch address, splits the instruction bytes into fields,
// predicts the next PC, and registers the fetched instruction into the
// F->D pipeline register.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-high reset
//   F_stall      hold predPC
//   D_stall      hold the D register (takes priority over D_bubble)
//   D_bubble     load a nop bubble into the D register
//   M_icode      memory-stage icode
//   M_cnd        memory-stage branch condition
//   M_valA       memory-stage fall-through address
//   W_icode      write-back-stage icode
//   W_valM       write-back-stage return address
//   imem_data    10 instruction bytes at f_pc, little-endian, byte0 = [7:0]
//   imem_error   f_pc is not a valid instruction address
//   f_pc         combinational fetch address
//   D_*          registered decode-stage fields
// -----------------------------------------------------------------------------
module pipe_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [63:0] f_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_MAX   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam dreg_t D_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    R_NONE,
        rb:    R_NONE,
        valc:  64'd0,
        valp:  64'd0
    };

    logic [63:0] pred_pc_q;
    logic [63:0] pred_pc_d;
    dreg_t       d_reg_q;
    dreg_t       d_reg_d;

    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic        need_regids;
    logic        need_valc;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic [63:0] f_valc;
    logic [63:0] f_valp;
    logic [2:0]  f_stat;

    // A mispredicted jump (taken was predicted) has highest priority, then a
    // returning ret, otherwise follow the prediction made last cycle.
    always_comb begin
        f_pc = pred_pc_q;
        if (M_icode == I_JXX && !M_cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end
    end

    // A bad fetch address turns the instruction into a nop so nothing
    // downstream acts on garbage bytes; the ADR status still flags it.
    always_comb begin
        f_icode = imem_data[7:4];
        f_ifun  = imem_data[3:0];
        if (imem_error) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end
    end

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (f_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: begin
                need_regids = 1'b0;
                need_valc   = 1'b0;
            end
        endcase
    end

    // The constant word starts right after the register byte when there is
    // one, otherwise right after the opcode byte.
    always_comb begin
        f_ra   = R_NONE;
        f_rb   = R_NONE;
        f_valc = 64'd0;
        if (need_regids) begin
            f_ra = imem_data[15:12];
            f_rb = imem_data[11:8];
        end
        if (need_valc) begin
            f_valc = need_regids ? imem_data[79:16] : imem_data[71:8];
        end
    end

    // Wraps modulo 2^64 by construction of the 64-bit sum.
    assign f_valp = f_pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'b000};

    always_comb begin
        f_stat = S_AOK;
        if (imem_error) begin
            f_stat = S_ADR;
        end else if (f_icode > I_MAX) begin
            f_stat = S_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = S_HLT;
        end
    end

    // Jumps are predicted taken and calls always go to their target.
    always_comb begin
        pred_pc_d = pred_pc_q;
        if (!F_stall) begin
            pred_pc_d = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;
        end
    end

    // Stall outranks bubble so a held instruction is never lost.
    always_comb begin
        d_reg_d = d_reg_q;
        if (!D_stall) begin
            if (D_bubble) begin
                d_reg_d = D_BUBBLE;
            end else begin
                d_reg_d.stat  = f_stat;
                d_reg_d.icode = f_icode;
                d_reg_d.ifun  = f_ifun;
                d_reg_d.ra    = f_ra;
                d_reg_d.rb    = f_rb;
                d_reg_d.valc  = f_valc;
                d_reg_d.valp  = f_valp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc_q <= 64'd0;
            d_reg_q   <= D_BUBBLE;
        end else begin
            pred_pc_q <= pred_pc_d;
            d_reg_q   <= d_reg_d;
        end
    end

    assign D_stat  = d_reg_q.stat;
    assign D_icode = d_reg_q.icode;
    assign D_ifun  = d_reg_q.ifun;
    assign D_rA    = d_reg_q.ra;
    assign D_rB    = d_reg_q.rb;
    assign D_valC  = d_reg_q.valc;
    assign D_valP  = d_reg_q.valp;

endmodule

// File: doc/pipe_fetch.md
PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: F_stall, D_stall, D_bubble  input  1 each  hazard-control requests.
REQ-004 SHALL have ports: M_icode  input  4, M_cnd  input  1, M_valA  input  64  memory-stage jump info (M_valA = fall-through address).
REQ-005 SHALL have ports: W_icode  input  4, W_valM  input  64  write-back-stage return info.
REQ-006 SHALL have ports: imem_data  input  80  bytes at f_pc, little-endian, byte0 = [7:0]; imem_error  input  1  bad fetch address.
REQ-007 SHALL have port: f_pc  output  64  combinational fetch address.
REQ-008 SHALL have ports: D_stat 3, D_icode 4, D_ifun 4, D_rA 4, D_rB 4, D_valC 64, D_valP 64  registered outputs to decode.
REQ-009 SHALL use encodings: icode halt=0, nop=1, jXX=7, call=8, ret=9, max valid=0xB; stat AOK=1, HLT=2, ADR=3, INS=4.

Function
REQ-010 SHALL hold predPC register (64 b).
REQ-011 SHALL select f_pc by priority: (M_icode==7 && !M_cnd) -> M_valA; else W_icode==9 -> W_valM; else predPC.
REQ-012 SHALL split: icode=byte0[7:4], ifun=byte0[3:0]; on imem_error force icode=1, ifun=0.
REQ-013 SHALL set need_regids for icode in {2,3,4,5,6,A,B}; need_valC for icode in {3,4,5,7,8}.
REQ-014 SHALL take rA=byte1[7:4], rB=byte1[3:0] when need_regids, else rA=rB=0xF.
REQ-015 SHALL take valC from bytes 2..9 when need_regids, else bytes 1..8 (little-endian); 0 when !need_valC.
REQ-016 SHALL compute valP = f_pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wrap, no flag).
REQ-017 SHALL set f_stat: ADR if imem_error; else INS if icode>0xB; else HLT if icode==0; else AOK.
REQ-018 SHALL set predicted PC = valC for icode 7 or 8, else valP.
REQ-019 SHALL load predPC with predicted PC each rising edge unless F_stall; F_stall holds predPC.
REQ-020 SHALL load D register from fetched fields each edge when neither D_stall nor D_bubble.
REQ-021 SHALL hold D register when D_stall=1, regardless of D_bubble (stall wins).
REQ-022 SHALL load bubble when D_bubble=1 and D_stall=0: stat=AOK, icode=1, ifun=0, rA=rB=0xF, valC=valP=0.
REQ-023 SHALL keep f_pc and all decode logic combinational; latency fetch->D outputs = 1 cycle.
REQ-024 SHALL continue fetching after HLT/ADR/INS; halting is by external F_stall/D_bubble only.

Reset
REQ-025 SHALL, while rst=1, force predPC=0 and D register to the bubble value of REQ-022, immediately (asynchronous).
REQ-026 SHALL, on rst deassertion, fetch from address 0 at the first following edge; rst mid-instruction discards all in-flight state.

Verification
REQ-027 SHALL cover: reset, imem at 0 = 30 F3 0A 00.. (irmovq) -> f_pc=0; after 1 edge D_icode=3, D_rA=F, D_rB=3, D_valC=0x0A, D_valP=0x0A, predPC=0x0A.
REQ-028 SHALL cover: f_pc=0x10, byte0=0x70, valC=0x100 -> predPC=0x100, D_valP=0x19; next cycle M_icode=7, M_cnd=0, M_valA=0x19 -> f_pc=0x19.
REQ-029 SHALL cover: W_icode=9, W_valM=0x40 with M_icode=1 -> f_pc=0x40; with M_icode=7, M_cnd=0 simultaneously -> f_pc=M_valA.
REQ-030 SHALL cover: D_stall=1 and D_bubble=1 same edge -> D outputs unchanged; D_bubble alone -> D_icode=1, D_stat=1; F_stall=1 -> predPC unchanged.
REQ-031 SHALL cover: byte0=0xC0 -> D_stat=4; imem_error=1 -> D_stat=3, D_icode=1; byte0=0x00 -> D_stat=2, D_valP=f_pc+1.
REQ-032 SHALL cover: predPC=0xFFFFFFFFFFFFFFFF, byte0=0x10 -> D_valP=0 (wrap); rst asserted mid-cycle -> D_icode=1, predPC=0 without clock edge.
